// File: rtl/cpu_debug_ctrl.sv
// Command-driven debug controller: loads/reads CPU memories, steps or runs the CPU,
// and stops on PC breakpoints or an external halt request.
module cpu_debug_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned N_BKPT = 4,
  parameter int unsigned STEP_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [2:0]        cmd_op_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_data_i,
  input  logic              halt_req_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_data_o,
  input  logic [ADDR_W-1:0] pc_chk_i,
  input  logic [DATA_W-1:0] dout_im_i,
  input  logic [DATA_W-1:0] dout_dm_i,
  input  logic [DATA_W-1:0] dout_rf_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] din_o,
  output logic              we_im_o,
  output logic              we_dm_o,
  output logic              clk_ld_o,
  output logic              debug_o,
  output logic              clk_cpu_en_o,
  output logic              halted_o
);

  localparam logic [2:0] OpWrIm    = 3'd0;
  localparam logic [2:0] OpWrDm    = 3'd1;
  localparam logic [2:0] OpRdIm    = 3'd2;
  localparam logic [2:0] OpRdDm    = 3'd3;
  localparam logic [2:0] OpRdRf    = 3'd4;
  localparam logic [2:0] OpStep    = 3'd5;
  localparam logic [2:0] OpRun     = 3'd6;
  localparam logic [2:0] OpSetBkpt = 3'd7;

  typedef enum logic [2:0] {
    StIdle, StWset, StWstb, StWend, StRset, StRcap, StStep, StRun
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic [2:0]          op_q, op_d;
  logic [STEP_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]   bkpt_pc_q [N_BKPT];
  logic [ADDR_W-1:0]   bkpt_pc_d [N_BKPT];
  logic [N_BKPT-1:0]   bkpt_en_q, bkpt_en_d;

  logic                match;
  logic [3:0]          match_idx;
  logic [DATA_W-1:0]   stop_word;
  logic [3:0]          bkpt_idx;
  logic                bkpt_we;

  // Descending scan so the lowest matching comparator wins.
  always_comb begin
    match     = 1'b0;
    match_idx = '0;
    for (int i = int'(N_BKPT) - 1; i >= 0; i--) begin
      if (bkpt_en_q[i] && (pc_chk_i == bkpt_pc_q[i])) begin
        match     = 1'b1;
        match_idx = 4'(i);
      end
    end
  end

  always_comb begin
    stop_word                 = '0;
    stop_word[DATA_W-1]       = match;
    stop_word[DATA_W-2 -: 4]  = match_idx;
  end

  assign bkpt_idx = cmd_addr_i[3:0];
  assign bkpt_we  = cmd_valid_i && (state_q == StIdle) && (cmd_op_i == OpSetBkpt) &&
                    (32'(bkpt_idx) < N_BKPT);

  always_comb begin
    bkpt_pc_d = bkpt_pc_q;
    bkpt_en_d = bkpt_en_q;
    for (int i = 0; i < int'(N_BKPT); i++) begin
      if (bkpt_we && (bkpt_idx == 4'(i))) begin
        bkpt_pc_d[i] = ADDR_W'(cmd_data_i);
        bkpt_en_d[i] = cmd_addr_i[ADDR_W-1];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    din_d        = din_q;
    op_d         = op_q;
    cnt_d        = cnt_q;
    cmd_ready_o  = 1'b0;
    we_im_o      = 1'b0;
    we_dm_o      = 1'b0;
    clk_ld_o     = 1'b0;
    clk_cpu_en_o = 1'b0;
    rsp_valid_o  = 1'b0;
    rsp_data_o   = '0;
    debug_o      = 1'b1;
    unique case (state_q)
      StIdle: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          op_d = cmd_op_i;
          unique case (cmd_op_i)
            OpWrIm, OpWrDm: begin
              addr_d  = cmd_addr_i;
              din_d   = cmd_data_i;
              state_d = StWset;
            end
            OpRdIm, OpRdDm, OpRdRf: begin
              addr_d  = cmd_addr_i;
              state_d = StRset;
            end
            OpStep: begin
              cnt_d = cmd_data_i[STEP_W-1:0];
              if (cmd_data_i[STEP_W-1:0] != '0) state_d = StStep;
            end
            OpRun:     state_d = StRun;
            OpSetBkpt: state_d = StIdle;
            default:   state_d = StIdle;
          endcase
        end
      end
      // Write enable brackets the one-cycle load strobe on both sides.
      StWset: begin
        we_im_o = (op_q == OpWrIm);
        we_dm_o = (op_q == OpWrDm);
        state_d = StWstb;
      end
      StWstb: begin
        we_im_o  = (op_q == OpWrIm);
        we_dm_o  = (op_q == OpWrDm);
        clk_ld_o = 1'b1;
        state_d  = StWend;
      end
      StWend: begin
        we_im_o = (op_q == OpWrIm);
        we_dm_o = (op_q == OpWrDm);
        state_d = StIdle;
      end
      StRset: state_d = StRcap;
      StRcap: begin
        rsp_valid_o = 1'b1;
        unique case (op_q)
          OpRdIm:  rsp_data_o = dout_im_i;
          OpRdDm:  rsp_data_o = dout_dm_i;
          default: rsp_data_o = dout_rf_i;
        endcase
        state_d = StIdle;
      end
      StStep: begin
        debug_o = 1'b0;
        if (halt_req_i) begin
          rsp_valid_o = 1'b1;
          cnt_d       = '0;
          state_d     = StIdle;
        end else begin
          clk_cpu_en_o = 1'b1;
          cnt_d        = cnt_q - STEP_W'(1);
          if (cnt_q == STEP_W'(1)) begin
            rsp_valid_o = 1'b1;
            state_d     = StIdle;
          end
        end
      end
      StRun: begin
        debug_o = 1'b0;
        if (match || halt_req_i) begin
          rsp_valid_o = 1'b1;
          rsp_data_o  = stop_word;
          state_d     = StIdle;
        end else begin
          clk_cpu_en_o = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign addr_o   = addr_q;
  assign din_o    = din_q;
  assign halted_o = ~clk_cpu_en_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      din_q     <= '0;
      op_q      <= '0;
      cnt_q     <= '0;
      bkpt_en_q <= '0;
      for (int i = 0; i < int'(N_BKPT); i++) bkpt_pc_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      din_q     <= din_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      bkpt_en_q <= bkpt_en_d;
      bkpt_pc_q <= bkpt_pc_d;
    end
  end

endmodule

// File: tb/tb_cpu_debug_ctrl.sv
// Directed bench for cpu_debug_ctrl with a tiny CPU model (PC counter, IM/DM arrays, fixed RF).
module tb_cpu_debug_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [2:0]  cmd_op_i = '0;
  logic [31:0] cmd_addr_i = '0;
  logic [31:0] cmd_data_i = '0;
  logic        halt_req_i = 1'b0;
  logic        rsp_valid_o;
  logic [31:0] rsp_data_o;
  logic [31:0] pc_chk_i;
  logic [31:0] dout_im_i, dout_dm_i, dout_rf_i;
  logic [31:0] addr_o, din_o;
  logic        we_im_o, we_dm_o, clk_ld_o, debug_o, clk_cpu_en_o, halted_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] im [256];
  logic [31:0] dm [256];
  logic        pc_set = 1'b0;
  logic [31:0] pc_set_val = '0;

  cpu_debug_ctrl dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_op_i     (cmd_op_i),
    .cmd_addr_i   (cmd_addr_i),
    .cmd_data_i   (cmd_data_i),
    .halt_req_i   (halt_req_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_data_o   (rsp_data_o),
    .pc_chk_i     (pc_chk_i),
    .dout_im_i    (dout_im_i),
    .dout_dm_i    (dout_dm_i),
    .dout_rf_i    (dout_rf_i),
    .addr_o       (addr_o),
    .din_o        (din_o),
    .we_im_o      (we_im_o),
    .we_dm_o      (we_dm_o),
    .clk_ld_o     (clk_ld_o),
    .debug_o      (debug_o),
    .clk_cpu_en_o (clk_cpu_en_o),
    .halted_o     (halted_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)           pc_chk_i <= '0;
    else if (pc_set)       pc_chk_i <= pc_set_val;
    else if (clk_cpu_en_o) pc_chk_i <= pc_chk_i + 32'd4;
  end

  always @(posedge clk_i) begin
    if (clk_ld_o && we_im_o) im[addr_o[7:0]] <= din_o;
    if (clk_ld_o && we_dm_o) dm[addr_o[7:0]] <= din_o;
  end

  assign dout_im_i = im[addr_o[7:0]];
  assign dout_dm_i = dm[addr_o[7:0]];
  assign dout_rf_i = 32'hA5A5_0000 | addr_o;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to the low phase of the next cycle, away from the active edge.
  task automatic cyc();
    @(negedge clk_i);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] d,
                      output int waits);
    cmd_valid_i = 1'b1;
    cmd_op_i    = op;
    cmd_addr_i  = a;
    cmd_data_i  = d;
    waits = 0;
    #1;
    while (!cmd_ready_o && waits < 20) begin
      cyc();
      waits++;
    end
    if (waits >= 20) check_eq("cmd_ready_timeout", 32'(cmd_ready_o), 32'd1);
    cyc();
    cmd_valid_i = 1'b0;
    #1;
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (!rsp_valid_o && n < 64) begin
      cyc();
      n++;
    end
    if (n >= 64) check_eq("rsp_timeout", 32'(rsp_valid_o), 32'd1);
  endtask

  task automatic set_pc(input logic [31:0] v);
    pc_set     = 1'b1;
    pc_set_val = v;
    cyc();
    pc_set = 1'b0;
    #1;
  endtask

  task automatic run_to_pc_then_halt(input logic [31:0] target);
    int n = 0;
    while (pc_chk_i != target && n < 40) begin
      cyc();
      n++;
    end
    check_eq("run_reach_pc", pc_chk_i, target);
    halt_req_i = 1'b1;
    #1;
  endtask

  initial begin
    int w;
    int en_cnt;

    #3;
    check_eq("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    check_eq("rst_debug", 32'(debug_o), 32'd1);
    check_eq("rst_halted", 32'(halted_o), 32'd1);
    check_eq("rst_cpu_en", 32'(clk_cpu_en_o), 32'd0);
    check_eq("rst_addr", addr_o, 32'd0);
    check_eq("rst_rsp", {rsp_data_o[30:0], rsp_valid_o}, 32'd0);
    cyc();
    rst_ni = 1'b1;
    cyc();

    // WR_IM 0x10 <= DEADBEEF: we across cycles 1-3, load strobe in cycle 2.
    send(3'd0, 32'h10, 32'hDEAD_BEEF, w);
    check_eq("wr_c1_we", {30'd0, we_im_o, clk_ld_o}, 32'b10);
    check_eq("wr_c1_addr", addr_o, 32'h10);
    check_eq("wr_c1_din", din_o, 32'hDEAD_BEEF);
    check_eq("wr_c1_ready", 32'(cmd_ready_o), 32'd0);
    cyc();
    check_eq("wr_c2_we", {30'd0, we_im_o, clk_ld_o}, 32'b11);
    cyc();
    check_eq("wr_c3_we", {30'd0, we_im_o, clk_ld_o}, 32'b10);
    check_eq("wr_c3_we_dm", 32'(we_dm_o), 32'd0);
    cyc();
    check_eq("wr_c4_we", {30'd0, we_im_o, clk_ld_o}, 32'b00);
    check_eq("wr_c4_ready", 32'(cmd_ready_o), 32'd1);

    // RD_IM 0x10
    send(3'd2, 32'h10, 32'd0, w);
    check_eq("rd_c1_valid", 32'(rsp_valid_o), 32'd0);
    cyc();
    check_eq("rd_c2_valid", 32'(rsp_valid_o), 32'd1);
    check_eq("rd_c2_data", rsp_data_o, 32'hDEAD_BEEF);
    cyc();
    check_eq("rd_c3_valid", 32'(rsp_valid_o), 32'd0);

    // RD_RF 3
    send(3'd4, 32'h3, 32'd0, w);
    cyc();
    check_eq("rdrf_data", rsp_data_o, 32'hA5A5_0003);
    cyc();

    // STEP 5 from PC 0
    send(3'd5, 32'd0, 32'd5, w);
    en_cnt = 0;
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) cyc();
      if (clk_cpu_en_o) en_cnt++;
      if (k == 1) check_eq("step_debug", 32'(debug_o), 32'd0);
      if (k == 5) check_eq("step_c5_rsp", {rsp_data_o[30:0], rsp_valid_o}, 32'd1);
      if (k == 5) check_eq("step_c5_ready", 32'(cmd_ready_o), 32'd0);
      if (k == 6) check_eq("step_c6_ready", 32'(cmd_ready_o), 32'd1);
    end
    check_eq("step_en_cycles", 32'(en_cnt), 32'd5);
    check_eq("step_pc", pc_chk_i, 32'h14);

    // Breakpoint 2 at 0x20, RUN from 0
    send(3'd7, 32'h8000_0002, 32'h20, w);
    set_pc(32'h0);
    send(3'd6, 32'd0, 32'd0, w);
    check_eq("run_c1_en", 32'(clk_cpu_en_o), 32'd1);
    wait_rsp();
    check_eq("bk2_pc", pc_chk_i, 32'h20);
    check_eq("bk2_en", 32'(clk_cpu_en_o), 32'd0);
    check_eq("bk2_match", 32'(rsp_data_o[31]), 32'd1);
    check_eq("bk2_idx", 32'(rsp_data_o[30:27]), 32'd2);
    cyc();
    check_eq("bk2_pc_hold", pc_chk_i, 32'h20);
    check_eq("bk2_ready", 32'(cmd_ready_o), 32'd1);

    // Breakpoints 1 and 3 both 0x8: lowest index reported
    send(3'd7, 32'h0000_0002, 32'h20, w);
    send(3'd7, 32'h8000_0003, 32'h8, w);
    send(3'd7, 32'h8000_0001, 32'h8, w);
    set_pc(32'h0);
    send(3'd6, 32'd0, 32'd0, w);
    wait_rsp();
    check_eq("bk13_pc", pc_chk_i, 32'h8);
    check_eq("bk13_word", rsp_data_o, 32'h8800_0000);
    cyc();

    // Clear 1/3; out-of-range index 5 must not alias onto a real comparator
    send(3'd7, 32'h0000_0001, 32'h8, w);
    send(3'd7, 32'h0000_0003, 32'h8, w);
    send(3'd7, 32'h8000_0005, 32'h4, w);
    set_pc(32'h0);
    send(3'd6, 32'd0, 32'd0, w);
    run_to_pc_then_halt(32'hC);
    check_eq("halt_en", 32'(clk_cpu_en_o), 32'd0);
    check_eq("halt_rsp_valid", 32'(rsp_valid_o), 32'd1);
    check_eq("halt_rsp_data", rsp_data_o, 32'h0);
    cyc();
    halt_req_i = 1'b0;
    #1;
    check_eq("halt_pc_hold", pc_chk_i, 32'hC);
    send(3'd5, 32'd0, 32'd1, w);
    cyc();
    check_eq("step1_pc", pc_chk_i, 32'h10);

    // STEP 0 is a no-op
    send(3'd5, 32'd0, 32'd0, w);
    check_eq("step0_en", 32'(clk_cpu_en_o), 32'd0);
    check_eq("step0_rsp", 32'(rsp_valid_o), 32'd0);
    check_eq("step0_ready", 32'(cmd_ready_o), 32'd1);
    check_eq("step0_pc", pc_chk_i, 32'h10);

    // Back-to-back WR_DM then RD_DM
    send(3'd1, 32'h20, 32'h1234_5678, w);
    send(3'd3, 32'h20, 32'd0, w);
    check_eq("b2b_wait", 32'(w), 32'd3);
    cyc();
    check_eq("b2b_rsp_valid", 32'(rsp_valid_o), 32'd1);
    check_eq("b2b_rsp_data", rsp_data_o, 32'h1234_5678);
    cyc();

    // Reset during WSTB, with breakpoint 0 armed at 0x4
    send(3'd7, 32'h8000_0000, 32'h4, w);
    send(3'd0, 32'h40, 32'h1, w);
    cyc();
    check_eq("mid_wstb_ld", {30'd0, we_im_o, clk_ld_o}, 32'b11);
    rst_ni = 1'b0;
    #1;
    check_eq("arst_we_ld", {30'd0, we_im_o, clk_ld_o}, 32'b00);
    check_eq("arst_cpu_en", 32'(clk_cpu_en_o), 32'd0);
    check_eq("arst_debug", 32'(debug_o), 32'd1);
    cyc();
    rst_ni = 1'b1;
    #1;
    check_eq("arst_ready", 32'(cmd_ready_o), 32'd1);
    send(3'd6, 32'd0, 32'd0, w);
    run_to_pc_then_halt(32'h8);
    check_eq("arst_bkpt_clear", rsp_data_o, 32'h0);
    cyc();
    halt_req_i = 1'b0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
